// File: rtl/csr_access_ctrl.sv
// -----------------------------------------------------------------------------
// csr_access_ctrl
//
// Sequences a single CSR instruction (CSRRW/S/C and immediate forms) against an
// external CSR file: one read cycle, one write cycle, then a held response.
// Also forwards a trap request to the CSR file as a one-cycle strobe. Only one
// operation is in flight at a time; busy_o is high whenever the FSM is not idle.
//
// Optional feature (define the macro to enable):
//   CSR_ACCESS_RO_CHECK_EN - requests to addresses with idx[11:10] == 2'b11 that
//                            would write are flagged illegal; the read still
//                            happens and the old value is returned, but the
//                            write is dropped.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_*                 CSR instruction request (valid/ready handshake)
//   rsp_*                 response: old CSR value and illegal flag (valid/ready)
//   csr_rd_en_o/wr_en_o   CSR file strobes; csr_idx_o/csr_wdata_o are zero
//                         whenever the matching strobe is low
//   csr_rdata_i           CSR file read data, sampled in the read cycle
//   exc_*                 trap request (valid/ready), accepted only when idle
//   trap_*                one-cycle trap strobe with registered cause and pc
//   busy_o                FSM not idle
// -----------------------------------------------------------------------------
module csr_access_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [11:0]     req_csr_idx_i,
  input  logic [4:0]      req_rs1_idx_i,
  input  logic [XLEN-1:0] req_rs1_data_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_illegal_o,
  output logic            csr_rd_en_o,
  output logic            csr_wr_en_o,
  output logic [11:0]     csr_idx_o,
  output logic [XLEN-1:0] csr_wdata_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  input  logic            exc_valid_i,
  input  logic [XLEN-1:0] exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  output logic            exc_ready_o,
  output logic            trap_active_o,
  output logic [XLEN-1:0] trap_cause_o,
  output logic [XLEN-1:0] trap_mepc_o,
  output logic            busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP,
    S_TRAP
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic [11:0]       idx_q;
  logic [4:0]        rs1_idx_q;
  logic [XLEN-1:0]   rs1_data_q;
  logic [XLEN-1:0]   old_q;
  logic              illegal_q;
  logic [XLEN-1:0]   cause_q;
  logic [XLEN-1:0]   pc_q;

  logic              bad_op_in;
  logic [XLEN-1:0]   src;
  logic [XLEN-1:0]   new_val;
  logic              no_write;
  logic              ro_hit;

  // funct3 x00 is not a CSR instruction.
  assign bad_op_in = (req_op_i[1:0] == 2'b00);

  // Immediate forms use the rs1 field itself as a zero-extended operand.
  assign src = op_q[2] ? XLEN'(rs1_idx_q) : rs1_data_q;

  always_comb begin
    unique case (op_q[1:0])
      2'b10:   new_val = old_q | src;
      2'b11:   new_val = old_q & ~src;
      default: new_val = src;
    endcase
  end

  // Set/clear with rs1 (or zimm) of zero must not produce a write side effect.
  assign no_write = (op_q[1:0] != 2'b01) && (rs1_idx_q == 5'd0);

`ifdef CSR_ACCESS_RO_CHECK_EN
  assign ro_hit = (idx_q[11:10] == 2'b11) && !no_write;
`else
  assign ro_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      idx_q      <= '0;
      rs1_idx_q  <= '0;
      rs1_data_q <= '0;
      old_q      <= '0;
      illegal_q  <= 1'b0;
      cause_q    <= '0;
      pc_q       <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (exc_valid_i) begin
            cause_q <= exc_cause_i;
            pc_q    <= exc_pc_i;
          end else if (req_valid_i) begin
            op_q       <= req_op_i;
            idx_q      <= req_csr_idx_i;
            rs1_idx_q  <= req_rs1_idx_i;
            rs1_data_q <= req_rs1_data_i;
            // Illegal ops skip the read, so the response data stays zero.
            old_q      <= '0;
            illegal_q  <= bad_op_in;
          end
        end
        S_READ:  old_q     <= csr_rdata_i;
        S_WRITE: illegal_q <= ro_hit;
        default: ;
      endcase
    end
  end

  // NOTE: every output and state_d gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d       = state_q;
    req_ready_o   = 1'b0;
    exc_ready_o   = 1'b0;
    rsp_valid_o   = 1'b0;
    rsp_rdata_o   = '0;
    rsp_illegal_o = 1'b0;
    csr_rd_en_o   = 1'b0;
    csr_wr_en_o   = 1'b0;
    csr_idx_o     = '0;
    csr_wdata_o   = '0;
    trap_active_o = 1'b0;
    trap_cause_o  = '0;
    trap_mepc_o   = '0;

    unique case (state_q)
      S_IDLE: begin
        exc_ready_o = 1'b1;
        // A pending trap blocks new requests.
        req_ready_o = !exc_valid_i;
        if (exc_valid_i)      state_d = S_TRAP;
        else if (req_valid_i) state_d = bad_op_in ? S_RESP : S_READ;
      end
      S_READ: begin
        csr_rd_en_o = 1'b1;
        csr_idx_o   = idx_q;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        if (!no_write && !ro_hit) begin
          csr_wr_en_o = 1'b1;
          csr_idx_o   = idx_q;
          csr_wdata_o = new_val;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o   = 1'b1;
        rsp_rdata_o   = old_q;
        rsp_illegal_o = illegal_q;
        if (rsp_ready_i) state_d = S_IDLE;
      end
      S_TRAP: begin
        trap_active_o = 1'b1;
        trap_cause_o  = cause_q;
        trap_mepc_o   = pc_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_csr_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_csr_access_ctrl
//
// Self-checking bench for csr_access_ctrl. A transaction-level model predicts,
// from the accept cycle of each request or trap, which strobes and responses
// must appear on which later cycle; it is compared with the DUT on every
// falling edge. The bench also owns the CSR file (an array) that the DUT reads
// and writes. Directed sequences with literal expectations come first, then
// randomized traffic including random resets.
// -----------------------------------------------------------------------------
module tb_csr_access_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [11:0]     req_csr_idx;
  logic [4:0]      req_rs1_idx;
  logic [XLEN-1:0] req_rs1_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_illegal;
  logic            csr_rd_en;
  logic            csr_wr_en;
  logic [11:0]     csr_idx;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            exc_valid;
  logic [XLEN-1:0] exc_cause;
  logic [XLEN-1:0] exc_pc;
  logic            exc_ready;
  logic            trap_active;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_mepc;
  logic            busy;

  always #5 clk = ~clk;

  csr_access_ctrl #(.XLEN(XLEN)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_i       (req_op),
    .req_csr_idx_i  (req_csr_idx),
    .req_rs1_idx_i  (req_rs1_idx),
    .req_rs1_data_i (req_rs1_data),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_illegal_o  (rsp_illegal),
    .csr_rd_en_o    (csr_rd_en),
    .csr_wr_en_o    (csr_wr_en),
    .csr_idx_o      (csr_idx),
    .csr_wdata_o    (csr_wdata),
    .csr_rdata_i    (csr_rdata),
    .exc_valid_i    (exc_valid),
    .exc_cause_i    (exc_cause),
    .exc_pc_i       (exc_pc),
    .exc_ready_o    (exc_ready),
    .trap_active_o  (trap_active),
    .trap_cause_o   (trap_cause),
    .trap_mepc_o    (trap_mepc),
    .busy_o         (busy)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // CSR file owned by the bench
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] mem [4096];
  bit              mem_init = 1'b0;

  assign csr_rdata = mem[csr_idx];

  // ---------------------------------------------------------------------------
  // Transaction-level reference model, evaluated on each falling edge
  // ---------------------------------------------------------------------------
  int              k = 0;         // falling-edge index
  bit              model_on = 1'b0;
  bit              pend = 1'b0;   // CSR request in flight
  bit              trap_pend = 1'b0;
  int              acc;           // falling edge on which the request was accepted
  int              rsp_at;        // first falling edge with a response
  bit              m_bad, m_wr, m_ill;
  logic [11:0]     m_idx;
  logic [XLEN-1:0] m_new, m_rdata, m_cause, m_pc;

  logic            e_busy, e_rr, e_er, e_rd, e_wr, e_rv, e_ill, e_trap;
  logic [11:0]     e_idx;
  logic [XLEN-1:0] e_wdata, e_rdata, e_cause, e_pc;
  logic [XLEN-1:0] t_src, t_old;
  bit              t_setclr, t_nowrite, t_ro;

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      mem_init = 1'b1;
    end

    e_busy = 0; e_rr = !exc_valid; e_er = 1; e_rd = 0; e_wr = 0; e_rv = 0;
    e_ill = 0; e_trap = 0; e_idx = '0; e_wdata = '0; e_rdata = '0;
    e_cause = '0; e_pc = '0;
    if (pend) begin
      e_busy = 1; e_rr = 0; e_er = 0;
      if (!m_bad && k == acc + 1) begin e_rd = 1; e_idx = m_idx; end
      if (m_wr && k == acc + 2) begin e_wr = 1; e_idx = m_idx; e_wdata = m_new; end
      if (k >= rsp_at) begin e_rv = 1; e_rdata = m_rdata; e_ill = m_ill; end
    end else if (trap_pend) begin
      e_busy = 1; e_rr = 0; e_er = 0; e_trap = 1; e_cause = m_cause; e_pc = m_pc;
    end

    if (model_on) begin
      check("mdl_req_ready",  32'(req_ready),   32'(e_rr));
      check("mdl_exc_ready",  32'(exc_ready),   32'(e_er));
      check("mdl_busy",       32'(busy),        32'(e_busy));
      check("mdl_rd_en",      32'(csr_rd_en),   32'(e_rd));
      check("mdl_wr_en",      32'(csr_wr_en),   32'(e_wr));
      check("mdl_csr_idx",    32'(csr_idx),     32'(e_idx));
      check("mdl_wdata",      csr_wdata,        e_wdata);
      check("mdl_rsp_valid",  32'(rsp_valid),   32'(e_rv));
      check("mdl_rsp_rdata",  rsp_rdata,        e_rdata);
      check("mdl_rsp_ill",    32'(rsp_illegal), 32'(e_ill));
      check("mdl_trap",       32'(trap_active), 32'(e_trap));
      check("mdl_trap_cause", trap_cause,       e_cause);
      check("mdl_trap_mepc",  trap_mepc,        e_pc);
    end

    // CSR file write port
    if (csr_wr_en) mem[csr_idx] = csr_wdata;

    if (rst) begin
      pend = 0; trap_pend = 0; model_on = 1;
    end else if (pend) begin
      if (e_rv && rsp_ready) pend = 0;
    end else if (trap_pend) begin
      trap_pend = 0;
    end else if (exc_valid) begin
      trap_pend = 1; m_cause = exc_cause; m_pc = exc_pc;
    end else if (req_valid) begin
      pend      = 1;
      acc       = k;
      m_idx     = req_csr_idx;
      m_bad     = (req_op == 3'b000) || (req_op == 3'b100);
      t_src     = req_op[2] ? XLEN'(req_rs1_idx) : req_rs1_data;
      t_old     = m_bad ? '0 : mem[req_csr_idx];
      case (req_op[1:0])
        2'b10:   m_new = t_old | t_src;
        2'b11:   m_new = t_old & ~t_src;
        default: m_new = t_src;
      endcase
      t_setclr  = (req_op[1:0] != 2'b01);
      t_nowrite = t_setclr && (req_rs1_idx == 5'd0);
`ifdef CSR_ACCESS_RO_CHECK_EN
      t_ro      = !m_bad && (req_csr_idx[11:10] == 2'b11) && !t_nowrite;
`else
      t_ro      = 1'b0;
`endif
      m_wr      = !m_bad && !t_nowrite && !t_ro;
      m_ill     = m_bad || t_ro;
      m_rdata   = t_old;
      rsp_at    = m_bad ? k + 1 : k + 3;
    end
    k++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request until accepted, then drops it. Returns #1 into the
  // cycle after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [11:0] idx,
                       input logic [4:0] r1, input logic [XLEN-1:0] d);
    bit got;
    got = 0;
    req_op = op; req_csr_idx = idx; req_rs1_idx = r1; req_rs1_data = d;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
      tick();
    end
    req_valid = 1'b0;
    check("accept_timeout", 32'(got), 32'd1);
  endtask

  bit exc_taken;

  initial begin
    rst = 1'b1; req_valid = 0; req_op = '0; req_csr_idx = '0; req_rs1_idx = '0;
    req_rs1_data = '0; rsp_ready = 1'b1; exc_valid = 0; exc_cause = '0; exc_pc = '0;
    tick();
    // Reset values, observed while reset is still asserted
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_exc_ready", 32'(exc_ready), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_strobes",   32'({csr_rd_en, csr_wr_en, trap_active}), 32'd0);
    check("rst_rdata",     rsp_rdata,      32'd0);
    tick();
    rst = 1'b0;

    // Preload 0x340 = 0x12 via CSRRW
    issue(3'b001, 12'h340, 5'd1, 32'h12);
    repeat (3) tick();

    // CSRRW 0x340 <- 0xDEADBEEF, old 0x12
    issue(3'b001, 12'h340, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("rw_rd_en",  32'(csr_rd_en), 32'd1);
    check("rw_rd_idx", 32'(csr_idx),   32'h340);
    tick(); @(negedge clk);
    check("rw_wr_en",  32'(csr_wr_en), 32'd1);
    check("rw_wdata",  csr_wdata,      32'hDEADBEEF);
    tick(); @(negedge clk);
    check("rw_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rw_rdata",     rsp_rdata,      32'h12);
    tick();

    // CSRRS with rs1=x0: read only
    issue(3'b001, 12'h300, 5'd1, 32'h88);
    repeat (3) tick();
    issue(3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF);
    tick(); @(negedge clk);
    check("rs0_no_wr", 32'(csr_wr_en), 32'd0);
    tick(); @(negedge clk);
    check("rs0_rdata", rsp_rdata, 32'h88);
    tick();

    // CSRRCI zimm 0x08 on 0x88 -> 0x80
    issue(3'b111, 12'h300, 5'h08, 32'h0);
    tick(); @(negedge clk);
    check("rci_wr_en", 32'(csr_wr_en), 32'd1);
    check("rci_wdata", csr_wdata,      32'h80);
    tick(); tick();

    // Trap and request in the same idle cycle: trap wins
    exc_valid = 1'b1; exc_cause = 32'h2; exc_pc = 32'h100;
    req_valid = 1'b1; req_op = 3'b001; req_csr_idx = 12'h340; req_rs1_idx = 5'd1;
    req_rs1_data = 32'h7;
    @(negedge clk);
    check("trap_req_blocked", 32'(req_ready), 32'd0);
    check("trap_exc_ready",   32'(exc_ready), 32'd1);
    tick();
    exc_valid = 1'b0;
    @(negedge clk);
    check("trap_active", 32'(trap_active), 32'd1);
    check("trap_cause",  trap_cause,       32'h2);
    check("trap_mepc",   trap_mepc,        32'h100);
    tick(); @(negedge clk);
    check("trap_one_cycle", 32'(trap_active), 32'd0);
    check("trap_then_req",  32'(req_ready),   32'd1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    check("trap_req_read", 32'(csr_rd_en), 32'd1);
    repeat (3) tick();

    // Response back-pressure: held 5 cycles, no new accept
    rsp_ready = 1'b0;
    issue(3'b001, 12'h340, 5'd2, 32'h55);
    tick(); tick();
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata",     rsp_rdata,      32'h7);
      check("bp_no_accept", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();

    // Illegal op 100: straight to response, no strobes
    issue(3'b100, 12'h340, 5'd3, 32'h1);
    @(negedge clk);
    check("ill_rsp_valid", 32'(rsp_valid),   32'd1);
    check("ill_flag",      32'(rsp_illegal), 32'd1);
    check("ill_rdata",     rsp_rdata,        32'h0);
    check("ill_strobes",   32'({csr_rd_en, csr_wr_en}), 32'd0);
    tick();

    // Reset during READ aborts with no write
    issue(3'b001, 12'h340, 5'd1, 32'h99);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_read", 32'(csr_rd_en), 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_wr", 32'(csr_wr_en), 32'd0);
      check("abort_idle",  32'(busy),      32'd0);
      tick();
    end
    issue(3'b010, 12'h340, 5'd0, 32'h0);
    tick(); tick(); @(negedge clk);
    check("abort_csr_kept", rsp_rdata, 32'h55);
    tick();

`ifdef CSR_ACCESS_RO_CHECK_EN
    // Write to read-only space: read happens, write dropped, flagged illegal
    issue(3'b001, 12'hC00, 5'd1, 32'hABCD);
    @(negedge clk);
    check("ro_rd_en", 32'(csr_rd_en), 32'd1);
    tick(); @(negedge clk);
    check("ro_no_wr", 32'(csr_wr_en), 32'd0);
    tick(); @(negedge clk);
    check("ro_illegal", 32'(rsp_illegal), 32'd1);
    check("ro_rdata",   rsp_rdata,        32'h0);
    tick();
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      exc_taken = exc_valid && exc_ready;
      tick();
      if (!exc_valid || exc_taken) begin
        exc_valid = ($urandom % 12 == 0);
        exc_cause = $urandom;
        exc_pc    = $urandom;
      end
      req_valid = ($urandom % 3 != 0);
      req_op    = 3'($urandom);
      case ($urandom % 4)
        0:       req_csr_idx = 12'h340;
        1:       req_csr_idx = 12'h300;
        2:       req_csr_idx = 12'hC00;
        default: req_csr_idx = 12'($urandom);
      endcase
      req_rs1_idx  = ($urandom % 3 == 0) ? 5'd0 : 5'($urandom);
      req_rs1_data = $urandom;
      rsp_ready    = ($urandom % 4 != 0);
      rst          = ($urandom % 200 == 0);
    end

    req_valid = 1'b0; exc_valid = 1'b0; rst = 1'b0; rsp_ready = 1'b1;
    repeat (6) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/csr_access_ctrl.md
CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

Interface
REQ-001 SHALL have parameter: XLEN, 32, data width of CSR values.
REQ-002 SHALL have clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have req_valid_i  input  1  CSR instruction request valid.
REQ-005 SHALL have req_ready_o  output  1  request accepted when high with req_valid_i.
REQ-006 SHALL have req_op_i  input  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
REQ-007 SHALL have req_csr_idx_i  input  12  CSR address.
REQ-008 SHALL have req_rs1_idx_i  input  5  rs1 index, or zimm for immediate ops.
REQ-009 SHALL have req_rs1_data_i  input  XLEN  rs1 value.
REQ-010 SHALL have rsp_valid_o / rsp_ready_i  output/input  1 each  response handshake.
REQ-011 SHALL have rsp_rdata_o  output  XLEN  old CSR value for rd.
REQ-012 SHALL have rsp_illegal_o  output  1  request was illegal.
REQ-013 SHALL have csr_rd_en_o, csr_wr_en_o  output  1 each  CSR file strobes.
REQ-014 SHALL have csr_idx_o  output  12, csr_wdata_o  output  XLEN, csr_rdata_i  input  XLEN  CSR file port.
REQ-015 SHALL have exc_valid_i  input  1, exc_cause_i  input  XLEN, exc_pc_i  input  XLEN  trap request.
REQ-016 SHALL have exc_ready_o  output  1  trap request accepted.
REQ-017 SHALL have trap_active_o  output  1, trap_cause_o  output  XLEN, trap_mepc_o  output  XLEN  trap strobe to CSR file.
REQ-018 SHALL have busy_o  output  1  high when FSM not in IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, RESP, TRAP.
REQ-020 IDLE: req_ready_o = exc_ready_o = 1 unless exc_valid_i; exc_valid_i takes priority (req_ready_o=0, next TRAP).
REQ-021 On request accept, SHALL register op, idx, rs1_idx, rs1_data; next READ.
REQ-022 READ: csr_rd_en_o=1, csr_idx_o=registered idx, capture csr_rdata_i as old; next WRITE.
REQ-023 Source src = op[2] ? zero-extended rs1_idx : rs1_data.
REQ-024 New value: RW/RWI src; RS/RSI old|src; RC/RCI old&~src; computed in XLEN bits.
REQ-025 WRITE: csr_wr_en_o=1 with csr_wdata_o=new, unless suppressed; next RESP.
REQ-026 Write suppressed when op is RS/RC/RSI/RCI and rs1_idx==0, or when illegal.
REQ-027 op 000 or 100 SHALL be illegal: no read, no write strobe; READ/WRITE skipped, next RESP with rsp_illegal_o=1, rsp_rdata_o=0.
REQ-028 RESP: rsp_valid_o=1, rsp_rdata_o=old, held stable until rsp_ready_i; on handshake next IDLE.
REQ-029 Legal-request latency: accept edge, READ cycle 1, WRITE cycle 2, rsp_valid_o from cycle 3.
REQ-030 TRAP: trap_active_o=1 for exactly one cycle with registered cause/pc; next IDLE.
REQ-031 exc_valid_i outside IDLE SHALL be ignored; requester holds it until exc_ready_o.
REQ-032 csr_rd_en_o, csr_wr_en_o, trap_active_o SHALL never be high in the same cycle.
REQ-033 csr_wdata_o, csr_idx_o SHALL be 0 when corresponding strobe is low.

Reset
REQ-034 rst_i SHALL force IDLE and clear all registered fields.
REQ-035 Reset values: req_ready_o=1, exc_ready_o=1, every other output 0.
REQ-036 Reset mid-operation SHALL abort without issuing pending write, response or trap strobe.

Configuration
REQ-037 Macro CSR_ACCESS_RO_CHECK_EN, when defined, SHALL mark a request illegal if idx[11:10]==2'b11 and write not suppressed: read performed, write suppressed, rsp_illegal_o=1, rsp_rdata_o=old.
REQ-038 Without CSR_ACCESS_RO_CHECK_EN, read-only address check SHALL be absent; only REQ-027 sets rsp_illegal_o.

Verification
REQ-039 CSRRW idx 0x340 rs1_data 0xDEADBEEF, CSR holds 0x12 -> rd_en cycle 1, wr_en cycle 2 wdata 0xDEADBEEF, rsp_rdata_o 0x12 cycle 3.
REQ-040 CSRRS idx 0x300 rs1_idx 0, CSR 0x88 -> no wr_en, rsp_rdata_o 0x88; CSRRCI zimm 0x08 on 0x88 -> wdata 0x80.
REQ-041 exc_valid_i and req_valid_i same IDLE cycle, cause 0x2, pc 0x100 -> trap_active_o one cycle with 0x2/0x100, req_ready_o=0, request accepted after.
REQ-042 rsp_ready_i low 5 cycles -> rsp_valid_o, rsp_rdata_o stable 5 cycles, no new accept; op 100 -> rsp_illegal_o=1, no strobes.
REQ-043 rst_i asserted in READ -> next cycle IDLE, no wr_en ever seen; with CSR_ACCESS_RO_CHECK_EN, CSRRW to 0xC00 -> rsp_illegal_o=1, no wr_en.
